// File: rtl/mole_driver.sv
// Lights one mole LED for on_ticks*TICK_DIV cycles and reports hit, miss or wrong-button.
// Latency: led/busy rise one cycle after start, and every outcome pulse is registered.
module mole_driver #(
    parameter int NUM_MOLES = 4,
    parameter int SEL_W     = 2,
    parameter int TICK_DIV  = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_W-1:0]     mole_sel,
    input  logic [7:0]           on_ticks,
    input  logic [NUM_MOLES-1:0] hit_pulse,
    output logic [NUM_MOLES-1:0] led,
    output logic                 busy,
    output logic                 hit,
    output logic                 miss,
    output logic                 wrong
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t               state, state_n;
    logic [SEL_W-1:0]     sel_r, sel_n;
    logic [7:0]           rem_r, rem_n;
    logic [PRE_W-1:0]     pre_r, pre_n;
    logic [NUM_MOLES-1:0] led_n;
    logic                 busy_n, hit_n, miss_n, wrong_n;

    logic [NUM_MOLES-1:0] sel_mask, start_mask;
    logic                 sel_ok, tick;

    assign sel_mask   = {{(NUM_MOLES-1){1'b0}}, 1'b1} << sel_r;
    assign start_mask = {{(NUM_MOLES-1){1'b0}}, 1'b1} << mole_sel;
    // Extra bit keeps the range check meaningful even when SEL_W exactly covers NUM_MOLES.
    assign sel_ok     = {1'b0, mole_sel} < (SEL_W+1)'(NUM_MOLES);
    assign tick       = (pre_r == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel_r <= '0;
            rem_r <= '0;
            pre_r <= '0;
            led   <= '0;
            busy  <= 1'b0;
            hit   <= 1'b0;
            miss  <= 1'b0;
            wrong <= 1'b0;
        end else begin
            state <= state_n;
            sel_r <= sel_n;
            rem_r <= rem_n;
            pre_r <= pre_n;
            led   <= led_n;
            busy  <= busy_n;
            hit   <= hit_n;
            miss  <= miss_n;
            wrong <= wrong_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_r;
        rem_n   = rem_r;
        pre_n   = pre_r;
        led_n   = '0;
        busy_n  = 1'b0;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        wrong_n = 1'b0;
        case (state)
            IDLE: begin
                if (start && sel_ok) begin
                    if (on_ticks == 8'd0) begin
                        miss_n = 1'b1;
                    end else begin
                        state_n = SHOW;
                        sel_n   = mole_sel;
                        rem_n   = on_ticks;
                        pre_n   = '0;
                        led_n   = start_mask;
                        busy_n  = 1'b1;
                    end
                end
            end
            SHOW: begin
                wrong_n = |(hit_pulse & ~sel_mask);
                pre_n   = tick ? '0 : pre_r + PRE_W'(1);
                // A correct press outranks an expiring window in the same cycle.
                if (|(hit_pulse & sel_mask)) begin
                    state_n = IDLE;
                    hit_n   = 1'b1;
                    rem_n   = '0;
                    pre_n   = '0;
                end else if (tick && rem_r == 8'd1) begin
                    state_n = IDLE;
                    miss_n  = 1'b1;
                    rem_n   = '0;
                    pre_n   = '0;
                end else begin
                    if (tick) rem_n = rem_r - 8'd1;
                    led_n  = sel_mask;
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mole_driver.sv
// Directed bench for mole_driver with TICK_DIV=4, NUM_MOLES=4 and a 3-bit select so bad indices can be driven.
module tb_mole_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mole_sel = '0;
    logic [7:0] on_ticks = '0;
    logic [3:0] hit_pulse = '0;
    logic [3:0] led;
    logic       busy, hit, miss, wrong;

    int checks = 0;
    int errors = 0;

    mole_driver #(.NUM_MOLES(4), .SEL_W(3), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mole_sel(mole_sel),
        .on_ticks(on_ticks), .hit_pulse(hit_pulse), .led(led),
        .busy(busy), .hit(hit), .miss(miss), .wrong(wrong)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({led, busy, hit, miss, wrong} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000000", {led, busy, hit, miss, wrong});
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if ({led, busy, hit, miss, wrong} !== 8'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 00000000", {led, busy, hit, miss, wrong});
        end
    endtask

    task automatic test_timeout();
        int cnt;
        start = 1'b1; mole_sel = 3'd2; on_ticks = 8'd3;
        cyc();
        start = 1'b0;
        checks++;
        if (led !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_first_cycle: led=%b busy=%b want 0100/1", led, busy);
        end
        cnt = 0;
        while (led === 4'b0100 && cnt < 40) begin
            cnt++;
            cyc();
        end
        checks++;
        if (cnt !== 12) begin
            errors++;
            $display("FAIL timeout_length: got %0d cycles want 12", cnt);
        end
        checks++;
        if (miss !== 1'b1 || busy !== 1'b0 || hit !== 1'b0 || led !== 4'b0) begin
            errors++;
            $display("FAIL timeout_miss: miss=%b busy=%b hit=%b led=%b want 1/0/0/0000", miss, busy, hit, led);
        end
        cyc();
        checks++;
        if (miss !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_miss_oneshot: miss=%b busy=%b want 0/0", miss, busy);
        end
    endtask

    task automatic test_hit_wrong();
        start = 1'b1; mole_sel = 3'd0; on_ticks = 8'd5;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        hit_pulse = 4'b0010;
        cyc();
        hit_pulse = 4'b0000;
        checks++;
        if (wrong !== 1'b1 || led !== 4'b0001 || busy !== 1'b1 || hit !== 1'b0) begin
            errors++;
            $display("FAIL wrong_pulse: wrong=%b led=%b busy=%b hit=%b want 1/0001/1/0", wrong, led, busy, hit);
        end
        cyc();
        checks++;
        if (wrong !== 1'b0 || led !== 4'b0001) begin
            errors++;
            $display("FAIL wrong_oneshot: wrong=%b led=%b want 0/0001", wrong, led);
        end
        cyc();
        hit_pulse = 4'b0001;
        cyc();
        hit_pulse = 4'b0000;
        checks++;
        if (hit !== 1'b1 || led !== 4'b0 || busy !== 1'b0 || miss !== 1'b0 || wrong !== 1'b0) begin
            errors++;
            $display("FAIL hit_pulse: hit=%b led=%b busy=%b miss=%b wrong=%b want 1/0000/0/0/0", hit, led, busy, miss, wrong);
        end
        cyc();
        checks++;
        if (hit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_oneshot: hit=%b busy=%b want 0/0", hit, busy);
        end
    endtask

    task automatic test_simultaneous();
        start = 1'b1; mole_sel = 3'd3; on_ticks = 8'd1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++;
        if (led !== 4'b1000) begin
            errors++;
            $display("FAIL simul_last_lit: led=%b want 1000", led);
        end
        hit_pulse = 4'b1000;
        cyc();
        hit_pulse = 4'b0000;
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0 || led !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_hit_wins: hit=%b miss=%b led=%b busy=%b want 1/0/0000/0", hit, miss, led, busy);
        end
        cyc();
        checks++;
        if (miss !== 1'b0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL simul_no_late_miss: hit=%b miss=%b want 0/0", hit, miss);
        end
    endtask

    task automatic test_illegal();
        int cnt;
        start = 1'b1; mole_sel = 3'd1; on_ticks = 8'd0;
        cyc();
        start = 1'b0;
        checks++;
        if (miss !== 1'b1 || led !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_dur_miss: miss=%b led=%b busy=%b want 1/0000/0", miss, led, busy);
        end
        cyc();
        checks++;
        if (miss !== 1'b0 || led !== 4'b0) begin
            errors++;
            $display("FAIL zero_dur_single: miss=%b led=%b want 0/0000", miss, led);
        end
        start = 1'b1; mole_sel = 3'd5; on_ticks = 8'd2;
        cyc();
        start = 1'b0;
        checks++;
        if ({led, busy, hit, miss, wrong} !== 8'b0) begin
            errors++;
            $display("FAIL bad_sel_ignored: got %b want 00000000", {led, busy, hit, miss, wrong});
        end
        cyc();
        checks++;
        if ({led, busy, miss} !== 6'b0) begin
            errors++;
            $display("FAIL bad_sel_quiet: got %b want 000000", {led, busy, miss});
        end
        start = 1'b1; mole_sel = 3'd1; on_ticks = 8'd2;
        cyc();
        start = 1'b0;
        cnt = 0;
        while (led === 4'b0010 && cnt < 40) begin
            cnt++;
            if (cnt == 3) begin
                start = 1'b1; mole_sel = 3'd3; on_ticks = 8'd5;
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        checks++;
        if (cnt !== 8) begin
            errors++;
            $display("FAIL busy_start_len: got %0d cycles want 8", cnt);
        end
        checks++;
        if (miss !== 1'b1 || led !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_end: miss=%b led=%b busy=%b want 1/0000/0", miss, led, busy);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int cnt;
        start = 1'b1; mole_sel = 3'd2; on_ticks = 8'd4;
        cyc();
        start = 1'b0;
        cyc();
        hit_pulse = 4'b0100;
        cyc();
        hit_pulse = 4'b0000;
        checks++;
        if (hit !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hit: hit=%b busy=%b want 1/0", hit, busy);
        end
        start = 1'b1; mole_sel = 3'd1; on_ticks = 8'd1;
        cyc();
        start = 1'b0;
        checks++;
        if (led !== 4'b0010 || busy !== 1'b1 || hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_relight: led=%b busy=%b hit=%b want 0010/1/0", led, busy, hit);
        end
        cnt = 0;
        while (led === 4'b0010 && cnt < 40) begin
            cnt++;
            cyc();
        end
        checks++;
        if (cnt !== 4 || miss !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_show: cycles=%0d miss=%b want 4/1", cnt, miss);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        bit bad;
        start = 1'b1; mole_sel = 3'd1; on_ticks = 8'd3;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        checks++;
        if (led !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: led=%b busy=%b want 0010/1", led, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: led=%b busy=%b want 0000/0", led, busy);
        end
        cyc();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if ({led, busy, hit, miss, wrong} !== 8'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: activity seen after reset, got %b want 0", bad);
        end
        start = 1'b1; mole_sel = 3'd0; on_ticks = 8'd1;
        cyc();
        start = 1'b0;
        checks++;
        if (led !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle_after: led=%b busy=%b want 0001/1", led, busy);
        end
        for (int i = 0; i < 6; i++) cyc();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_hit_wrong();
        test_simultaneous();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_driver.md
# mole_driver

Output-side counterpart to the debounced button path in the whack-a-mole game. It lights one mole LED for a programmed duration. It then reports one of two outcomes: the player whacked the matching button in time (hit), or the window expired (miss). Game control issues single-cycle show requests; the per-button one-shot pulses from the button detectors feed back into this block.

## Interface
Parameters:
- NUM_MOLES, 4, number of mole LEDs/buttons
- SEL_W, 2, width of mole_sel (≥ clog2(NUM_MOLES))
- TICK_DIV, 50000, clk cycles per timing tick (≥ 2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle show request
- mole_sel  in  SEL_W  index of mole to light, sampled with start
- on_ticks  in  8  show duration in ticks, sampled with start
- hit_pulse  in  NUM_MOLES  one-cycle press pulses, one bit per button
- led  out  NUM_MOLES  mole LEDs, one-hot while showing
- busy  out  1  high while a show is in progress
- hit  out  1  one-cycle pulse: correct button pressed in window
- miss  out  1  one-cycle pulse: window expired
- wrong  out  1  one-cycle pulse: non-selected button pressed during window

## Operation
- Reset values: led=0, busy=0, hit=0, miss=0, wrong=0, state=IDLE, prescaler=0, remaining=0.
- States are IDLE and SHOW. All outputs are registered.
- **IDLE to SHOW**
  - Condition: start=1, mole_sel < NUM_MOLES, and on_ticks ≠ 0.
  - Latch sel and remaining=on_ticks, and clear the prescaler.
- **Zero duration:** start=1 with on_ticks=0 (valid sel) stays in IDLE and pulses miss the next cycle. The LED never lights.
- **Bad select:** start=1 with mole_sel ≥ NUM_MOLES is ignored, with no outputs.
- **In SHOW:**
  - led = one-hot(sel) and busy=1.
  - The prescaler counts 0..TICK_DIV-1. Wrapping produces a tick, and each tick decrements remaining.
- **Hit:** hit_pulse[sel]=1 → next edge: IDLE, led=0, busy=0, hit=1 for one cycle.
- **Timeout:** a tick with remaining=1 → next edge: IDLE, led=0, busy=0, miss=1 for one cycle.
- **Hit and timeout in the same cycle:** hit wins, and miss stays low.
- **Wrong button:** any hit_pulse bit other than sel is set in SHOW → wrong=1 next cycle.
  - The show continues.
  - If the correct bit is also set in that cycle, both hit and wrong pulse.
- **hit_pulse in IDLE:** ignored.
- **start while busy=1:** ignored; the latched sel and on_ticks are unchanged.
- **Reset mid-show:** all outputs drop immediately (asynchronously). No hit or miss is reported.

## Timing
- start sampled at edge N → led and busy high from N+1.
- Undisturbed show: led high for exactly on_ticks×TICK_DIV cycles. The miss pulse occupies the first cycle after the LED falls, and busy falls in that same cycle.
- Hit latency: hit_pulse high in cycle M → hit high, led low, busy low in cycle M+1.
- Back-to-back shows: busy is low in the cycle hit or miss is high, so a start in that cycle is accepted. Its LED lights one cycle later.
- Arithmetic widths:
  - The prescaler is wide enough for TICK_DIV-1.
  - remaining is 8 bits and never wraps; it only decrements from ≥1.

## Test plan
(All scenarios run with TICK_DIV=4 and NUM_MOLES=4.)
- Reset mid-show: start sel=1, on_ticks=3; assert rst at cycle 5 → led=0, busy=0 immediately. No hit or miss follows, and the block is IDLE after release.
- Timeout: start sel=2, on_ticks=3 → led=4'b0100 for exactly 12 cycles, then miss=1 for one cycle, then busy=0.
- Hit and wrong: start sel=0, on_ticks=5.
  - hit_pulse=4'b0010 at cycle 3 → wrong=1 at cycle 4, and led stays 4'b0001.
  - hit_pulse=4'b0001 at cycle 6 → hit=1 at cycle 7, led=0.
- Simultaneous events: start sel=3, on_ticks=1, with hit_pulse=4'b1000 in the last lit cycle → hit=1, miss=0.
- Illegal starts:
  - start with on_ticks=0 → a single miss, and led is never set.
  - start during busy with a different sel → ignored, and the original LED and duration are unaffected.
- Back-to-back: start asserted in the same cycle as hit → the new led is one-hot at the next edge, with no idle gap beyond one cycle.
